cic_round_scheduler: RTL
========================

Name: cic_round_scheduler

Overview:
- Round-robin scheduler that shares one rounding/saturation unit between NUM_CH CIC channel outputs.
- Accepts wide accumulator samples from each channel over a valid/ready handshake and issues them one at a time to the shared rounder, which is combinational.
- Captures the rounded result, tags it with its channel ID and presents it downstream over a valid/ready handshake.
- Tracks a per-channel saturation sticky flag and an optional per-channel saturation counter.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- ACC_WIDTH, 42, accumulator sample width from the channels and to the rounder.
- OUT_WIDTH, 16, rounded sample width.
- CNT_WIDTH, 16, width of each saturation event counter.
- ID_W, $clog2(NUM_CH) (localparam), channel ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ch_data_in  in  NUM_CH*ACC_WIDTH  packed channel samples; channel i occupies bits [i*ACC_WIDTH +: ACC_WIDTH]
- ch_valid_in  in  NUM_CH  per-channel sample valid
- ch_ready_out  out  NUM_CH  per-channel accept; one-hot or zero
- rnd_data_o  out  ACC_WIDTH  sample issued to the rounder
- rnd_valid_o  out  1  issue valid
- rnd_data_i  in  OUT_WIDTH  rounder result
- rnd_overflow_i  in  1  rounder overflow
- rnd_underflow_i  in  1  rounder underflow
- rnd_valid_i  in  1  rounder valid_out
- data_out  out  OUT_WIDTH  rounded sample
- ch_id_out  out  ID_W  channel ID of data_out
- sat_out  out  1  data_out was clipped (overflow or underflow)
- valid_out  out  1  output valid
- ready_in  in  1  downstream ready
- sat_clr  in  NUM_CH  per-channel clear for the sticky flag and counter
- sat_sticky  out  NUM_CH  per-channel saturation sticky flag
- sat_cnt_sel  in  ID_W  counter read select
- sat_cnt_out  out  CNT_WIDTH  selected counter value
- proto_err  out  1  sticky flag: rnd_valid_i was low while rnd_valid_o was high

Behaviour:
- Two-stage pipeline.
  - Stage I (issue register) holds a sample and its ID, with flag i_full.
  - Stage O (output register) holds the rounded result, ID and sat bit, with flag o_full.
  - rnd_data_o = stage I data; rnd_valid_o = i_full.
  - valid_out = o_full.
- Stage movement:
  - o_adv = i_full & (~o_full | ready_in).
  - i_acc = ~i_full | o_adv.
- Arbitration:
  - When i_acc is high and any ch_valid_in is high, grant the first valid channel searching from rr_ptr upward, modulo NUM_CH.
  - ch_ready_out[g] = 1 in that same cycle; at most one bit of ch_ready_out is high.
  - On accept, rr_ptr <= (g+1) mod NUM_CH; otherwise rr_ptr holds.
  - ch_ready_out is combinational from ch_valid_in; channels must not make valid depend on ready.
- Latency and throughput:
  - Accept at cycle N gives rnd_valid_o at N+1 and valid_out at N+2 (if no stall).
  - Full throughput is one sample per cycle when ready_in is held high.
- Output capture: on o_adv, stage O <= {rnd_data_i, stage I ID, rnd_overflow_i | rnd_underflow_i}.
- Output hold: when o_full & ~ready_in, data_out, ch_id_out and sat_out stay stable; stage I stalls; ch_ready_out = 0 if i_full.
- Sticky flags:
  - sat_sticky[id] sets on o_adv when the captured sat bit is 1.
  - sat_clr[i] clears bit i.
  - A set and a clear on the same channel in the same cycle: set wins.
- proto_err: sets when i_full & ~rnd_valid_i; cleared only by rst.
- Reset:
  - All outputs 0; i_full, o_full, rr_ptr, sat_sticky and proto_err all 0.
  - Reset mid-operation discards in-flight samples with no output.
- Boundary conditions:
  - All channels valid: grants rotate 0,1,2,3,0,...
  - Single valid channel: granted every accept cycle.
  - NUM_CH not a power of two: rr_ptr wraps at NUM_CH-1 -> 0.

Optional Feature:
- Macro: CIC_SAT_CNT_EN.
- Defined:
  - Per-channel CNT_WIDTH counter increments by 1 on each saturated capture for that channel.
  - Counter saturates at all-ones (no wrap).
  - sat_clr[i] zeroes counter i; increment and clear in the same cycle leaves the counter at 1.
  - sat_cnt_out is registered: counter[sat_cnt_sel] one cycle later.
  - Counters reset to 0.
- Not defined: no counters; sat_cnt_out tied to 0.

Test Plan:
- Test 1: Reset, then ch_valid_in=4'b1111 held, ready_in=1, with a behavioural rounder (ACC_FRAC 32, OUT_FRAC 15) -> grants 0,1,2,3,0; first valid_out at cycle 2 after first accept; ch_id_out sequence 0,1,2,3; one output per cycle.
- Test 2: ch2 sends 0x00080000000 (0.5) -> data_out=0x4000, sat_out=0, ch_id_out=2.
- Test 3: ch1 sends 0x1FFFFFFFFFF -> data_out=0x7FFF, sat_out=1, sat_sticky=4'b0010; pulse sat_clr[1] in the same cycle as a second saturating capture -> sticky stays 1.
- Test 4: ready_in=0 for 5 cycles with all channels valid -> exactly 2 accepts, then ch_ready_out=0, data_out stable; release -> no sample lost or duplicated, order preserved.
- Test 5: Assert rst for 1 cycle while both stages are full -> valid_out=0, rnd_valid_o=0 next cycle, rr_ptr=0 (next grant goes to ch0), sticky flags cleared.
- Test 6 (CIC_SAT_CNT_EN): 3 saturating samples on ch3, sat_cnt_sel=3 -> sat_cnt_out=3 one cycle later; with CNT_WIDTH=2 and 5 events -> value stays at 3.

Source files
------------

// File: rtl/cic_round_scheduler.sv
// cic_round_scheduler: round-robin sharing of one rounder across NUM_CH CIC channels.
// Define CIC_SAT_CNT_EN to add per-channel saturating saturation-event counters.
module cic_round_scheduler #(
  parameter int NUM_CH = 4,
  parameter int ACC_WIDTH = 42,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16,
  localparam int ID_W = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*ACC_WIDTH-1:0] ch_data_in,
  input  logic [NUM_CH-1:0]           ch_valid_in,
  output logic [NUM_CH-1:0]           ch_ready_out,
  output logic [ACC_WIDTH-1:0]        rnd_data_o,
  output logic                        rnd_valid_o,
  input  logic [OUT_WIDTH-1:0]        rnd_data_i,
  input  logic                        rnd_overflow_i,
  input  logic                        rnd_underflow_i,
  input  logic                        rnd_valid_i,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic [ID_W-1:0]             ch_id_out,
  output logic                        sat_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  input  logic [NUM_CH-1:0]           sat_clr,
  output logic [NUM_CH-1:0]           sat_sticky,
  input  logic [ID_W-1:0]             sat_cnt_sel,
  output logic [CNT_WIDTH-1:0]        sat_cnt_out,
  output logic                        proto_err
);
  logic i_full, o_full, o_adv, i_acc, accept, sat_now;
  logic [ACC_WIDTH-1:0] i_data;
  logic [ID_W-1:0] i_id, rr_ptr, g;
  logic [ID_W:0] sum;
  logic [NUM_CH-1:0] sat_set;
  assign o_adv = i_full & (~o_full | ready_in);
  assign i_acc = ~i_full | o_adv;
  assign accept = i_acc & (|ch_valid_in);
  assign rnd_data_o = i_data;
  assign rnd_valid_o = i_full;
  assign valid_out = o_full;
  assign sat_now = rnd_overflow_i | rnd_underflow_i;
  assign sat_set = {NUM_CH{o_adv & sat_now}} & (NUM_CH'(1) << i_id);
  assign ch_ready_out = {NUM_CH{accept}} & (NUM_CH'(1) << g);
  // Walk downward so the closest valid channel at or after rr_ptr wins last.
  always_comb begin
    g = '0;
    sum = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      sum = (sum >= (ID_W+1)'(NUM_CH)) ? sum - (ID_W+1)'(NUM_CH) : sum;
      g = ch_valid_in[sum[ID_W-1:0]] ? sum[ID_W-1:0] : g;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      i_full <= 1'b0;
      o_full <= 1'b0;
      rr_ptr <= '0;
      i_data <= '0;
      i_id <= '0;
      data_out <= '0;
      ch_id_out <= '0;
      sat_out <= 1'b0;
      sat_sticky <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        i_full <= 1'b1;
        i_data <= ch_data_in[g*ACC_WIDTH +: ACC_WIDTH];
        i_id <= g;
        rr_ptr <= (g == ID_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
      end else if (o_adv) begin
        i_full <= 1'b0;
      end
      if (o_adv) begin
        o_full <= 1'b1;
        data_out <= rnd_data_i;
        ch_id_out <= i_id;
        sat_out <= sat_now;
      end else if (ready_in) begin
        o_full <= 1'b0;
      end
      sat_sticky <= (sat_sticky & ~sat_clr) | sat_set;
      if (i_full & ~rnd_valid_i) proto_err <= 1'b1;
    end
  end
`ifdef CIC_SAT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt [NUM_CH];
  // A clear coinciding with an event leaves the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '{default: '0};
      sat_cnt_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        cnt[i] <= sat_clr[i] ? CNT_WIDTH'(sat_set[i]) : cnt[i] + CNT_WIDTH'(sat_set[i] & ~&cnt[i]);
      sat_cnt_out <= cnt[sat_cnt_sel];
    end
  end
`else
  assign sat_cnt_out = '0;
`endif
endmodule
